deploy_ctrl: RTL

DEPLOY_CTRL -- requirements
Module: deploy_ctrl

---
 rtl/game_pkg.sv | 28 ++
 rtl/spawn_fifo.sv | 55 +++++
 rtl/deploy_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the deploy path: elixir economy, cooldown,
// deploy FSM states and the spawn queue entry.
package game_pkg;

  localparam int unsigned CANVAS_WIDTH_DEF    = 360;
  localparam int unsigned CANVAS_HEIGHT_DEF   = 720;
  localparam int unsigned SPAWN_X_W           = $clog2(CANVAS_WIDTH_DEF);
  localparam int unsigned SPAWN_Y_W           = $clog2(CANVAS_HEIGHT_DEF);

  localparam int unsigned ELIXIR_W            = 4;
  localparam int unsigned ELIXIR_MAX_DEF      = 10;
  localparam int unsigned ELIXIR_START_DEF    = 5;
  localparam int unsigned REGEN_FRAMES_DEF    = 168;
  localparam int unsigned CARD_COST_DEF       = 3;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 30;
  localparam int unsigned SPAWN_FIFO_DEPTH    = 4;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } deploy_state_t;

  typedef struct packed {
    logic [SPAWN_X_W-1:0] x;
    logic [SPAWN_Y_W-1:0] y;
  } spawn_t;

endpackage

// File: rtl/spawn_fifo.sv
// First-word-fall-through queue of pending spawns; head is driven straight
// from storage so it stays stable while the consumer stalls.
module spawn_fifo
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = SPAWN_FIFO_DEPTH,
  parameter type         T     = spawn_t
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic valid,
  output T     head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign valid   = (cnt != '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/deploy_ctrl.sv
// Turns mouse clicks on the player's half into queued troop spawns, gated by
// elixir, a per-deploy cooldown and queue space.
module deploy_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CANVAS_WIDTH    = CANVAS_WIDTH_DEF,
  parameter int unsigned CANVAS_HEIGHT   = CANVAS_HEIGHT_DEF,
  parameter int unsigned ELIXIR_MAX      = ELIXIR_MAX_DEF,
  parameter int unsigned ELIXIR_START    = ELIXIR_START_DEF,
  parameter int unsigned REGEN_FRAMES    = REGEN_FRAMES_DEF,
  parameter int unsigned CARD_COST       = CARD_COST_DEF,
  parameter int unsigned DEPLOY_Y_MIN    = 360,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             new_frame,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]  mouse_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0] mouse_y,
  input  logic                             click,
  input  logic                             spawn_ready,
  output logic                             spawn_valid,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  spawn_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] spawn_y,
  output logic [3:0]                       elixir,
  output logic                             reject
);

  localparam int unsigned RW = $clog2(REGEN_FRAMES);
  localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);

  deploy_state_t state, state_nxt;
  logic          click_q;
  logic          click_rise;
  logic [RW-1:0] regen_cnt, regen_nxt;
  logic [CW-1:0] cd_cnt, cd_nxt;
  logic          gain;
  logic          accept;
  logic          refuse;
  logic          deploy_ok;
  logic          fifo_full;
  spawn_t        push_data;
  spawn_t        head;

  assign click_rise = click & ~click_q;
  assign deploy_ok  = (32'(mouse_y) >= DEPLOY_Y_MIN) && (32'(mouse_x) < CANVAS_WIDTH)
                   && (32'(elixir) >= CARD_COST) && !fifo_full;

  always_comb begin
    state_nxt = state;
    cd_nxt    = cd_cnt;
    accept    = 1'b0;
    refuse    = 1'b0;
    case (state)
      READY: begin
        if (click_rise) begin
          if (deploy_ok) begin
            accept    = 1'b1;
            cd_nxt    = CW'(COOLDOWN_FRAMES);
            state_nxt = COOLDOWN;
          end else begin
            refuse = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        // Counter sits at 0 for one cycle before READY, so exit lags the last frame.
        if (cd_cnt == '0) begin
          state_nxt = READY;
        end else if (new_frame) begin
          cd_nxt = cd_cnt - 1'b1;
        end
      end
      default: state_nxt = READY;
    endcase
  end

  always_comb begin
    gain      = 1'b0;
    regen_nxt = regen_cnt;
    if (32'(elixir) >= ELIXIR_MAX) begin
      regen_nxt = '0;
    end else if (new_frame) begin
      if (32'(regen_cnt) == REGEN_FRAMES - 1) begin
        regen_nxt = '0;
        gain      = 1'b1;
      end else begin
        regen_nxt = regen_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= READY;
      click_q   <= 1'b1;
      regen_cnt <= '0;
      cd_cnt    <= '0;
      elixir    <= 4'(ELIXIR_START);
      reject    <= 1'b0;
    end else begin
      state     <= state_nxt;
      click_q   <= click;
      regen_cnt <= regen_nxt;
      cd_cnt    <= cd_nxt;
      elixir    <= elixir + 4'(gain) - (accept ? 4'(CARD_COST) : 4'd0);
      reject    <= refuse;
    end
  end

  assign push_data = '{x: mouse_x, y: mouse_y};

  spawn_fifo #(
    .DEPTH (SPAWN_FIFO_DEPTH),
    .T     (spawn_t)
  ) u_spawn_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (accept),
    .push_data (push_data),
    .pop       (spawn_ready),
    .full      (fifo_full),
    .valid     (spawn_valid),
    .head      (head)
  );

  assign spawn_x = head.x;
  assign spawn_y = head.y;

endmodule
